// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests, applies stalls and
// redirects, and holds the IF/ID register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] NPC_IF_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic [31:0] pc_out
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic        fire;
  logic        stall;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign redirect = jump_taken | branch_taken;
  assign target   = (jump_taken ? jump_target : branch_target) & 32'hFFFF_FFFC;
  assign stall    = ~pc_write | ~if_id_write;
  assign fire     = imem_ready & pc_write & if_id_write & ~redirect;
  assign pc_inc   = pc_q + 32'(PC_STEP);

  always_comb begin
    pc_d    = pc_q;
    npc_d   = npc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = target;
      npc_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (fire) begin
      pc_d    = pc_inc;
      npc_d   = pc_inc;
      instr_d = imem_rdata;
      valid_d = 1'b1;
    end else if (!stall) begin
      // Memory bubble: PC waits, decode receives a NOP.
      npc_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      npc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Request is held low only while reset is asserted.
  assign imem_req        = rst_n;
  assign imem_addr       = pc_q;
  assign pc_out          = pc_q;
  assign NPC_IF_out      = npc_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, if_id_write;
  logic        branch_taken, jump_taken;
  logic [31:0] branch_target, jump_target;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_req, imem_ready;
  logic [31:0] npc, instr, pc;
  logic        valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .NPC_IF_out(npc), .instruction_out(instr),
    .valid_out(valid), .pc_out(pc)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2001_0005 : (a ^ 32'hA5A5_0000);
  endfunction

  always_comb imem_rdata = word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_npc,
                        input logic [31:0] e_instr, input logic e_valid);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".npc"}, npc, e_npc);
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, e_valid});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
    jump_taken = j; jump_target = jt; branch_taken = b; branch_target = bt;
  endtask

  initial begin
    rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1; imem_ready = 1'b1;
    redir(1'b0, '0, 1'b0, '0);
    #3;
    chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("reset.req", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    #7 rst_n = 1'b1;
    chk("release.req", {31'b0, imem_req}, 32'h1);
    chk("release.addr", imem_addr, 32'h0);

    step(); chk_if("seq0", 32'h4, 32'h4, 32'h2001_0005, 1'b1);
    step(); chk_if("seq1", 32'h8, 32'h8, word(32'h4), 1'b1);

    pc_write = 1'b0; if_id_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_if("stall", 32'h8, 32'h8, word(32'h4), 1'b1);
    end
    pc_write = 1'b1; if_id_write = 1'b1;
    step(); chk_if("unstall", 32'hC, 32'hC, word(32'h8), 1'b1);
    step(); chk_if("seq2", 32'h10, 32'h10, word(32'hC), 1'b1);

    redir(1'b0, '0, 1'b1, 32'h40);
    step(); chk_if("branch", 32'h40, 32'h0, 32'h0, 1'b0);
    redir(1'b0, '0, 1'b0, '0);
    step(); chk_if("branch_tgt", 32'h44, 32'h44, word(32'h40), 1'b1);

    redir(1'b1, 32'h103, 1'b1, 32'h200); pc_write = 1'b0;
    step(); chk_if("prio", 32'h100, 32'h0, 32'h0, 1'b0);
    pc_write = 1'b1;

    redir(1'b1, 32'h20, 1'b0, '0);
    step(); chk_if("to20", 32'h20, 32'h0, 32'h0, 1'b0);
    redir(1'b0, '0, 1'b0, '0); imem_ready = 1'b0;
    step(); chk_if("wait0", 32'h20, 32'h0, 32'h0, 1'b0);
    step(); chk_if("wait1", 32'h20, 32'h0, 32'h0, 1'b0);
    imem_ready = 1'b1;
    step(); chk_if("wait_done", 32'h24, 32'h24, word(32'h20), 1'b1);

    imem_ready = 1'b0; redir(1'b1, 32'h80, 1'b0, '0);
    step(); chk_if("redir_noready", 32'h80, 32'h0, 32'h0, 1'b0);
    chk("redir_noready.addr", imem_addr, 32'h80);
    imem_ready = 1'b1;

    redir(1'b0, '0, 1'b1, 32'h60);
    step(); chk_if("consec0", 32'h60, 32'h0, 32'h0, 1'b0);
    redir(1'b1, 32'h71, 1'b0, '0);
    step(); chk_if("consec1", 32'h70, 32'h0, 32'h0, 1'b0);

    redir(1'b1, 32'hFFFF_FFFF, 1'b0, '0);
    step(); chk_if("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    redir(1'b0, '0, 1'b0, '0);
    step(); chk_if("wrap", 32'h0, 32'h0, word(32'hFFFF_FFFC), 1'b1);

    redir(1'b1, 32'h44, 1'b0, '0);
    step(); chk_if("to44", 32'h44, 32'h0, 32'h0, 1'b0);
    redir(1'b0, '0, 1'b0, '0);
    step(); chk_if("at48", 32'h48, 32'h48, word(32'h44), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_if("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("async_rst.req", {31'b0, imem_req}, 32'h0);
    #2 rst_n = 1'b1;
    #1 chk_if("post_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    step(); chk_if("post_rst_fetch", 32'h4, 32'h4, 32'h2001_0005, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
